// File: rtl/hex_disp_ctrl.sv
// Hex display controller. A load scans the value MSD first through a shared
// hex-to-segment decoder into a shadow register. After the scan, the shadow
// is committed atomically to the displayed bytes. A free-running prescaler
// drives an optional blink that blanks the whole display on alternate phases.
module hex_disp_ctrl #(
  parameter int NDIGITS   = 6,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic                   blank_lz,
  input  logic                   blink_en,
  input  logic [NDIGITS-1:0]     dot_mask,
  output logic [3:0]             dec_nibble,
  input  logic [7:0]             dec_led,
  output logic [8*NDIGITS-1:0]   hex,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [IDX_W-1:0] IDX_MSD  = IDX_W'(NDIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_accept;
  logic                   w_load_ready;
  logic                   w_busy;

  logic [4*NDIGITS-1:0]   r_val;
  logic                   r_blank_lz;
  logic                   r_blink_cap;
  logic [NDIGITS-1:0]     r_dot;

  logic [IDX_W-1:0]       r_idx;
  logic                   r_lz;
  logic [8*NDIGITS-1:0]   r_sh;
  logic [8*NDIGITS-1:0]   w_sh_nxt;
  logic [8*NDIGITS-1:0]   r_disp;
  logic                   r_done;
  logic                   r_blink_act;

  logic [CNT_W-1:0]       r_presc;
  logic                   r_phase;

  logic [3:0]             w_nib;
  logic                   w_dot;
  logic                   w_blank;
  logic [7:0]             w_byte;

  // FSM state register; reset aborts any scan in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_load_ready = 1'b0;
    w_busy       = 1'b1;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        w_load_ready = 1'b1;
        w_busy       = 1'b0;
        if (load_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (r_idx == '0) w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Select the digit under scan and form its shadow byte
  always_comb begin
    w_nib = '0;
    w_dot = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib = r_val[i*4 +: 4];
        w_dot = r_dot[i];
      end
    end
    // Digit 0 is never blanked so a zero value still shows "0"
    w_blank = r_blank_lz & r_lz & (w_nib == 4'd0) & (r_idx != '0);
    w_byte  = w_blank ? 8'hFF : {dec_led[7] & ~w_dot, dec_led[6:0]};
  end

  // Shadow byte update for the digit being scanned
  always_comb begin
    w_sh_nxt = r_sh;
    for (int i = 0; i < NDIGITS; i++) begin
      if ((r_state == SCAN) && (r_idx == IDX_W'(i))) w_sh_nxt[i*8 +: 8] = w_byte;
    end
  end

  // Load capture; data path needs no reset since a scan always follows
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_val       <= value;
      r_blank_lz  <= blank_lz;
      r_blink_cap <= blink_en;
      r_dot       <= dot_mask;
    end
  end

  // Scan index and leading-zero tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= IDX_MSD;
      r_lz  <= 1'b1;
    end else if (w_accept) begin
      r_idx <= IDX_MSD;
      r_lz  <= 1'b1;
    end else if (r_state == SCAN) begin
      if (r_idx != '0)   r_idx <= r_idx - IDX_W'(1);
      if (w_nib != 4'd0) r_lz  <= 1'b0;
    end
  end

  // Shadow register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sh <= '1;
    else        r_sh <= w_sh_nxt;
  end

  // Atomic commit of the shadow into the displayed bytes, with done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp      <= '1;
      r_done      <= 1'b0;
      r_blink_act <= 1'b0;
    end else begin
      r_done <= (r_state == COMMIT);
      if (r_state == COMMIT) begin
        r_disp      <= r_sh;
        r_blink_act <= r_blink_cap;
      end
    end
  end

  // Free-running blink prescaler, independent of loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_phase <= 1'b0;
    end else if (r_presc == CNT_LAST) begin
      r_presc <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_presc <= r_presc + CNT_W'(1);
    end
  end

  assign load_ready = w_load_ready;
  assign busy       = w_busy;
  assign done       = r_done;
  assign dec_nibble = (r_state == SCAN) ? w_nib : 4'd0;
  assign hex        = (r_blink_act & r_phase) ? '1 : r_disp;

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Bench for hex_disp_ctrl: directed loads with a transaction-level model
// checked every cycle, plus literal expectations for the key patterns.
module tb_hex_disp_ctrl;

  localparam int ND = 6;
  localparam int BD = 4;

  logic            clk        = 1'b0;
  logic            rst_n      = 1'b1;
  logic [4*ND-1:0] value      = '0;
  logic            load_valid = 1'b0;
  logic            blank_lz   = 1'b0;
  logic            blink_en   = 1'b0;
  logic [ND-1:0]   dot_mask   = '0;
  logic            load_ready;
  logic [3:0]      dec_nibble;
  logic [7:0]      dec_led;
  logic [8*ND-1:0] hex;
  logic            busy;
  logic            done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 8'hC0; 4'h1: seg = 8'hF9; 4'h2: seg = 8'hA4; 4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99; 4'h5: seg = 8'h92; 4'h6: seg = 8'h82; 4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80; 4'h9: seg = 8'h90; 4'hA: seg = 8'h88; 4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6; 4'hD: seg = 8'hA1; 4'hE: seg = 8'h86; default: seg = 8'h8E;
    endcase
  endfunction

  assign dec_led = seg(dec_nibble);

  hex_disp_ctrl #(.NDIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load_valid(load_valid),
    .load_ready(load_ready), .blank_lz(blank_lz), .blink_en(blink_en),
    .dot_mask(dot_mask), .dec_nibble(dec_nibble), .dec_led(dec_led),
    .hex(hex), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [4*ND-1:0] v, input int i);
    nib = 4'(v >> (4*i));
  endfunction

  // Whole-display expectation: digits above the most significant nonzero
  // digit are blanked (never digit 0) when blanking is on.
  function automatic logic [8*ND-1:0] exp_hex(input logic [4*ND-1:0] v,
                                               input logic bl, input logic [ND-1:0] dm);
    int msd;
    logic [7:0] b;
    msd = -1;
    for (int i = 0; i < ND; i++) if (nib(v, i) != 4'd0) msd = i;
    exp_hex = '0;
    for (int i = 0; i < ND; i++) begin
      if (bl && (i > msd) && (i != 0)) b = 8'hFF;
      else begin
        b = seg(nib(v, i));
        if (dm[i]) b[7] = 1'b0;
      end
      exp_hex[i*8 +: 8] = b;
    end
  endfunction

  // Transaction model: m_left counts remaining busy cycles of a load
  int              m_left       = 0;
  int              m_n          = 0;
  logic [8*ND-1:0] m_disp       = '1;
  logic [8*ND-1:0] m_pend       = '1;
  logic            m_blink      = 1'b0;
  logic            m_pend_blink = 1'b0;
  logic            m_done       = 1'b0;
  logic [4*ND-1:0] m_scan       = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_n     <= 0;
      m_disp  <= '1;
      m_blink <= 1'b0;
      m_done  <= 1'b0;
    end else begin
      m_n    <= m_n + 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_disp  <= m_pend;
        m_blink <= m_pend_blink;
      end
      if ((m_left == 0) && load_valid) begin
        m_left       <= ND + 1;
        m_pend       <= exp_hex(value, blank_lz, dot_mask);
        m_pend_blink <= blink_en;
        m_scan       <= value;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [8*ND-1:0] eh;
    logic [3:0]      en;
    eh = (m_blink && (((m_n / BD) % 2) == 1)) ? '1 : m_disp;
    en = (m_left >= 2) ? nib(m_scan, m_left - 2) : 4'd0;
    chk("hex",        64'(hex),        64'(eh));
    chk("done",       64'(done),       64'(m_done));
    chk("busy",       64'(busy),       64'(m_left != 0));
    chk("load_ready", 64'(load_ready), 64'(m_left == 0));
    chk("dec_nibble", 64'(dec_nibble), 64'(en));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one load for a single cycle; returns in cycle T+1
  task automatic start_load(input logic [4*ND-1:0] v, input logic bl,
                            input logic bk, input logic [ND-1:0] dm);
    value = v; blank_lz = bl; blink_en = bk; dot_mask = dm;
    load_valid = 1'b1;
    tick(1);
    load_valid = 1'b0;
  endtask

  initial begin
    int nff;
    int nval;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_hex",   64'(hex),        64'(48'hFFFF_FFFF_FFFF));
    chk("rst_busy",  64'(busy),       64'd0);
    chk("rst_ready", 64'(load_ready), 64'd1);
    chk("rst_done",  64'(done),       64'd0);
    chk("rst_nib",   64'(dec_nibble), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("model_pin", 64'(exp_hex(24'h0123AB, 1'b0, 6'b0)), 64'(48'hC0F9_A4B0_8883));

    // Basic load, no blanking: done only in T+8
    start_load(24'h0123AB, 1'b0, 1'b0, 6'b0);
    chk("t1_busy", 64'(busy), 64'd1);
    tick(6);
    chk("t1_done_t7", 64'(done), 64'd0);
    chk("t1_hex_t7",  64'(hex),  64'(48'hFFFF_FFFF_FFFF));
    tick(1);
    chk("t1_hex",  64'(hex),  64'(48'hC0F9_A4B0_8883));
    chk("t1_done", 64'(done), 64'd1);
    tick(1);
    chk("t1_done_t9", 64'(done), 64'd0);

    start_load(24'h0123AB, 1'b1, 1'b0, 6'b0);
    tick(7);
    chk("t2_hex", 64'(hex), 64'(48'hFFF9_A4B0_8883));

    start_load(24'h000000, 1'b1, 1'b0, 6'b0);
    tick(7);
    chk("t3_hex", 64'(hex), 64'(48'hFFFF_FFFF_FFC0));

    start_load(24'h000008, 1'b0, 1'b0, 6'b000001);
    tick(7);
    chk("t4_hex", 64'(hex), 64'(48'hC0C0_C0C0_C000));

    // load_valid held while busy: second value waits for load_ready
    value = 24'h456789; blank_lz = 1'b0; blink_en = 1'b0; dot_mask = '0;
    load_valid = 1'b1;
    tick(1);
    value = 24'h00FEDC;
    chk("t5_ready_t1", 64'(load_ready), 64'd0);
    tick(6);
    chk("t5_ready_t7", 64'(load_ready), 64'd0);
    tick(1);
    chk("t5_hex_a",   64'(hex),        64'(48'h9992_82F8_8090));
    chk("t5_ready_8", 64'(load_ready), 64'd1);
    chk("t5_done_8",  64'(done),       64'd1);
    tick(1);
    load_valid = 1'b0;
    chk("t5_busy_b", 64'(busy), 64'd1);
    tick(7);
    chk("t5_hex_b", 64'(hex), 64'(48'hC0C0_8E86_A1C6));

    // Blink: half-period of BD cycles, then steady after reload
    start_load(24'h0000A5, 1'b1, 1'b1, 6'b0);
    tick(7);
    nff = 0; nval = 0;
    for (int k = 0; k < 16; k++) begin
      if (hex == 48'hFFFF_FFFF_FFFF) nff++;
      else if (hex == 48'hFFFF_FFFF_8892) nval++;
      tick(1);
    end
    chk("t6_blink_ff",  64'(nff),  64'd8);
    chk("t6_blink_val", 64'(nval), 64'd8);
    start_load(24'h0000A5, 1'b1, 1'b0, 6'b0);
    tick(7);
    nval = 0;
    for (int k = 0; k < 12; k++) begin
      if (hex == 48'hFFFF_FFFF_8892) nval++;
      tick(1);
    end
    chk("t6_steady", 64'(nval), 64'd12);

    // Reset in the middle of a scan
    start_load(24'h0123AB, 1'b0, 1'b0, 6'b0);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_hex_async",   64'(hex),        64'(48'hFFFF_FFFF_FFFF));
    chk("t7_busy_async",  64'(busy),       64'd0);
    chk("t7_ready_async", 64'(load_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    value = 24'h000007; blank_lz = 1'b0; blink_en = 1'b0; dot_mask = '0;
    load_valid = 1'b1;
    rst_n = 1'b1;
    chk("t7_ready_rel", 64'(load_ready), 64'd1);
    tick(1);
    load_valid = 1'b0;
    chk("t7_busy_first", 64'(busy), 64'd1);
    chk("t7_hex_norest", 64'(hex),  64'(48'hFFFF_FFFF_FFFF));
    tick(7);
    chk("t7_hex_new", 64'(hex),  64'(48'hC0C0_C0C0_C0F8));
    chk("t7_done",    64'(done), 64'd1);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
